// File: rtl/mfp_ahb_param_ic.sv
// mfp_ahb_param_ic: parametrised single-master AHB-lite interconnect.
// Decodes HADDR against per-slave base/mask pairs, fans the address phase out
// as a one-hot HSEL, and routes the selected slave's data-phase response back
// to the master. Unmapped NONSEQ/SEQ transfers are answered by a built-in
// default slave with a two-cycle ERROR, and are recorded in a small error log.
module mfp_ahb_param_ic #(
    parameter int                     N_SLAVES = 9,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK = {N_SLAVES{32'h1FF00000}}
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [N_SLAVES-1:0]      HSEL,
    input  logic [N_SLAVES*32-1:0]   HRDATA_S,
    input  logic [N_SLAVES-1:0]      HREADYOUT_S,
    input  logic [N_SLAVES-1:0]      HRESP_S,
    output logic [31:0]              ERR_ADDR,
    output logic                     ERR_WRITE,
    output logic [7:0]               ERR_COUNT
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    logic [N_SLAVES-1:0] w_hsel;
    logic                w_found;
    logic                w_nomatch;
    logic                w_err_accept;
    logic [N_SLAVES-1:0] r_sel_d;
    ds_state_e           r_ds_state;
    ds_state_e           w_ds_next;
    logic                w_ds_ready;
    logic                w_ds_resp;
    logic [31:0]         r_err_addr;
    logic                r_err_write;
    logic [7:0]          r_err_count;

    // Address decode: the lowest matching index wins, so HSEL is one-hot or zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_hsel  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!w_found && ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                w_hsel[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign HSEL         = w_hsel;
    assign w_nomatch    = ~|w_hsel;
    // An unmapped active transfer is accepted only when the bus is ready.
    assign w_err_accept = w_nomatch & HTRANS[1] & HREADY;

    // Data-phase select: loads on a completed data phase, holds through wait states.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
        if (!HRESETn) begin
            r_sel_d <= '0;
        end else if (HREADY) begin
            r_sel_d <= w_hsel;
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ds_state <= DS_IDLE;
        end else begin
            r_ds_state <= w_ds_next;
        end
    end

    // Default-slave next state: ERROR is a stall cycle then a completing cycle.
    always_comb begin
        w_ds_next = r_ds_state;
        case (r_ds_state)
            DS_IDLE: if (w_err_accept) w_ds_next = DS_ERR1;
            DS_ERR1: w_ds_next = DS_ERR2;
            DS_ERR2: w_ds_next = w_err_accept ? DS_ERR1 : DS_IDLE;
            default: w_ds_next = DS_IDLE;
        endcase
    end

    // Default-slave outputs, decoded from state only.
    always_comb begin
        w_ds_ready = 1'b1;
        w_ds_resp  = 1'b0;
        case (r_ds_state)
            DS_ERR1: begin
                w_ds_ready = 1'b0;
                w_ds_resp  = 1'b1;
            end
            DS_ERR2: w_ds_resp = 1'b1;
            default: ;
        endcase
    end

    // Data-phase return mux: selected slave, or the default slave when none.
    always_comb begin
        HRDATA = '0;
        HREADY = w_ds_ready;
        HRESP  = w_ds_resp;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_sel_d[i]) begin
                HRDATA = HRDATA_S[32*i +: 32];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

    // Error log: capture and count every accepted unmapped NONSEQ/SEQ transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_addr  <= '0;
            r_err_write <= 1'b0;
            r_err_count <= '0;
        end else if (w_err_accept) begin
            r_err_addr  <= HADDR;
            r_err_write <= HWRITE;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign ERR_ADDR  = r_err_addr;
    assign ERR_WRITE = r_err_write;
    assign ERR_COUNT = r_err_count;

endmodule
